// File: rtl/mil_pkg.sv
// -----------------------------------------------------------------------------
// mil_pkg
// Shared definitions for the MIL-STD-1553 receive message buffer:
//   - command-word field bit positions (RT, T/R, SA, WC)
//   - broadcast terminal address
//   - controller state encoding
//   - wc_to_n(): word count field to data-word count (WC=0 means 32)
// -----------------------------------------------------------------------------
package mil_pkg;

    localparam int RT_HI  = 15;
    localparam int RT_LO  = 11;
    localparam int TR_BIT = 10;
    localparam int SA_HI  = 9;
    localparam int SA_LO  = 5;
    localparam int WC_HI  = 4;
    localparam int WC_LO  = 0;

    localparam logic [4:0] BCAST_ADDR = 5'd31;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    // Number of data words announced by a command word; WC=0 encodes 32.
    function automatic logic [5:0] wc_to_n(input logic [15:0] cw);
        logic [4:0] wc;
        wc = cw[WC_HI:WC_LO];
        return (wc == 5'd0) ? 6'd32 : {1'b0, wc};
    endfunction

endpackage

// File: rtl/mil_ram_sdp.sv
// -----------------------------------------------------------------------------
// mil_ram_sdp
// Simple dual-port RAM: one write port, one read port, synchronous read.
// Ports:
//   clk    - clock
//   R_n    - synchronous active-low reset (clears the read data register only)
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   re     - read enable
//   raddr  - read address
//   rdata  - registered read data, updated only when re=1
// -----------------------------------------------------------------------------
module mil_ram_sdp #(
    parameter int AW = 6,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          R_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!R_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/mil_rx_msg_buf.sv
// -----------------------------------------------------------------------------
// mil_rx_msg_buf
// Assembles complete MIL-STD-1553 receive messages (one command word plus N
// data words) from the receiver word strobe, stores each message atomically in
// a ring FIFO and hands committed words to the host read port.
// Ports:
//   clk      - system clock
//   R_n      - synchronous active-low reset
//   ce       - received-word strobe (1 cycle)
//   DAT_RX   - received word, valid with ce
//   CW_DW    - 1 = command word, 0 = data word, valid with ce
//   ce_us    - 1 us tick used for the inter-word gap timeout
//   rd_en    - host read request
//   rd_dat   - read word
//   rd_vld   - rd_dat valid (one cycle after an accepted read)
//   empty    - no committed word available
//   msg_cnt  - committed messages whose header has not been read yet
//   msg_rdy  - one-cycle pulse after a message commits
//   err_to   - sticky gap timeout
//   err_ovf  - sticky overflow (message rejected for lack of space)
//   err_seq  - sticky data word received outside a message
// -----------------------------------------------------------------------------
module mil_rx_msg_buf
    import mil_pkg::*;
#(
    parameter int         AW      = 6,
    parameter logic [4:0] RT_ADDR = 5'd1,
    parameter bit         FILT_EN = 1'b1,
    parameter logic [7:0] GAP_MAX = 8'd24
) (
    input  logic          clk,
    input  logic          R_n,
    input  logic          ce,
    input  logic [15:0]   DAT_RX,
    input  logic          CW_DW,
    input  logic          ce_us,
    input  logic          rd_en,
    output logic [15:0]   rd_dat,
    output logic          rd_vld,
    output logic          empty,
    output logic [AW:0]   msg_cnt,
    output logic          msg_rdy,
    output logic          err_to,
    output logic          err_ovf,
    output logic          err_seq
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    state_t      state, state_n;
    logic [AW:0] wr_ptr, wr_ptr_n;
    logic [AW:0] wr_cmt, wr_cmt_n;
    logic [AW:0] rd_ptr;
    logic [5:0]  rem, rem_n;
    logic [7:0]  gap, gap_n;
    logic [7:0]  gap_inc;

    logic        we;
    logic [AW:0] waddr;
    logic        commit, set_to, set_ovf, set_seq;

    logic [4:0]  cw_rt;
    logic        cw_acc;
    logic [5:0]  cw_n;
    logic [AW:0] used, free, need;

    logic        rd_fire, hdr_pend, hdr_rd;
    logic [5:0]  rd_rem, rem_eff;

    // Command word decode and space check. Occupancy is measured against the
    // committed pointer: a CW arriving mid-message discards the partial one
    // first, and in IDLE wr_ptr equals wr_cmt anyway.
    assign cw_rt   = DAT_RX[RT_HI:RT_LO];
    assign cw_n    = wc_to_n(DAT_RX);
    assign cw_acc  = !DAT_RX[TR_BIT] &&
                     (!FILT_EN || cw_rt == RT_ADDR || cw_rt == BCAST_ADDR);
    assign used    = wr_cmt - rd_ptr;
    assign free    = DEPTH - used;
    assign need    = (AW+1)'(cw_n) + 1'b1;
    assign gap_inc = gap + 8'd1;

    always_comb begin
        state_n  = state;
        wr_ptr_n = wr_ptr;
        wr_cmt_n = wr_cmt;
        rem_n    = rem;
        gap_n    = gap;
        we       = 1'b0;
        waddr    = wr_ptr;
        commit   = 1'b0;
        set_to   = 1'b0;
        set_ovf  = 1'b0;
        set_seq  = 1'b0;

        case (state)
            IDLE: begin
                if (ce && !CW_DW) begin
                    set_seq = 1'b1;
                end
            end
            COLLECT: begin
                if (ce && !CW_DW) begin
                    we       = 1'b1;
                    wr_ptr_n = wr_ptr + 1'b1;
                    rem_n    = rem - 6'd1;
                    gap_n    = 8'd0;
                    if (rem == 6'd1) begin
                        wr_cmt_n = wr_ptr + 1'b1;
                        commit   = 1'b1;
                        state_n  = IDLE;
                    end
                end else if (!ce && ce_us) begin
                    // A word in the same cycle as the last tick takes priority.
                    if (gap_inc == GAP_MAX) begin
                        wr_ptr_n = wr_cmt;
                        gap_n    = 8'd0;
                        set_to   = 1'b1;
                        state_n  = IDLE;
                    end else begin
                        gap_n = gap_inc;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Any CW drops a partial message and is then judged as if in IDLE.
        if (ce && CW_DW) begin
            wr_ptr_n = wr_cmt;
            state_n  = IDLE;
            if (cw_acc) begin
                if (free >= need) begin
                    we       = 1'b1;
                    waddr    = wr_cmt;
                    wr_ptr_n = wr_cmt + 1'b1;
                    rem_n    = cw_n;
                    gap_n    = 8'd0;
                    state_n  = COLLECT;
                end else begin
                    set_ovf = 1'b1;
                end
            end
        end
    end

    // Read side: only committed words are visible. The header of each message
    // is recognised by counting down its announced words; the WC of a header
    // read last cycle is taken straight from rd_dat so back-to-back reads work.
    assign empty   = (rd_ptr == wr_cmt);
    assign rd_fire = rd_en && !empty;
    assign rem_eff = hdr_pend ? wc_to_n(rd_dat) : rd_rem;
    assign hdr_rd  = rd_fire && (rem_eff == 6'd0);

    always_ff @(posedge clk) begin
        if (!R_n) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            wr_cmt   <= '0;
            rd_ptr   <= '0;
            rem      <= '0;
            gap      <= '0;
            msg_cnt  <= '0;
            rd_vld   <= 1'b0;
            msg_rdy  <= 1'b0;
            err_to   <= 1'b0;
            err_ovf  <= 1'b0;
            err_seq  <= 1'b0;
            rd_rem   <= '0;
            hdr_pend <= 1'b0;
        end else begin
            state   <= state_n;
            wr_ptr  <= wr_ptr_n;
            wr_cmt  <= wr_cmt_n;
            rem     <= rem_n;
            gap     <= gap_n;
            msg_rdy <= commit;
            rd_vld  <= rd_fire;
            err_to  <= err_to  | set_to;
            err_ovf <= err_ovf | set_ovf;
            err_seq <= err_seq | set_seq;

            if (rd_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            if (hdr_rd) begin
                hdr_pend <= 1'b1;
            end else begin
                hdr_pend <= 1'b0;
                rd_rem   <= rd_fire ? rem_eff - 6'd1 : rem_eff;
            end

            case ({commit, hdr_rd})
                2'b10:   msg_cnt <= msg_cnt + 1'b1;
                2'b01:   msg_cnt <= msg_cnt - 1'b1;
                default: msg_cnt <= msg_cnt;
            endcase
        end
    end

    mil_ram_sdp #(
        .AW (AW),
        .DW (16)
    ) u_ram (
        .clk   (clk),
        .R_n   (R_n),
        .we    (we),
        .waddr (waddr[AW-1:0]),
        .wdata (DAT_RX),
        .re    (rd_fire),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_dat)
    );

endmodule

// File: tb/tb_mil_rx_msg_buf.sv
// -----------------------------------------------------------------------------
// tb_mil_rx_msg_buf
// Directed bench for mil_rx_msg_buf. A message-level model (queues of words)
// predicts every output each cycle; literal expectations pin the key results.
// -----------------------------------------------------------------------------
module tb_mil_rx_msg_buf;

    localparam int         AW  = 6;
    localparam logic [4:0] RT  = 5'd1;
    localparam int         GAP = 24;

    logic          clk;
    logic          R_n;
    logic          ce;
    logic [15:0]   DAT_RX;
    logic          CW_DW;
    logic          ce_us;
    logic          rd_en;
    logic [15:0]   rd_dat;
    logic          rd_vld;
    logic          empty;
    logic [AW:0]   msg_cnt;
    logic          msg_rdy;
    logic          err_to;
    logic          err_ovf;
    logic          err_seq;

    mil_rx_msg_buf #(
        .AW      (AW),
        .RT_ADDR (RT),
        .FILT_EN (1'b1),
        .GAP_MAX (8'(GAP))
    ) dut (
        .clk     (clk),
        .R_n     (R_n),
        .ce      (ce),
        .DAT_RX  (DAT_RX),
        .CW_DW   (CW_DW),
        .ce_us   (ce_us),
        .rd_en   (rd_en),
        .rd_dat  (rd_dat),
        .rd_vld  (rd_vld),
        .empty   (empty),
        .msg_cnt (msg_cnt),
        .msg_rdy (msg_rdy),
        .err_to  (err_to),
        .err_ovf (err_ovf),
        .err_seq (err_seq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nbad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nbad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] cq[$];   // committed, unread words
    bit          ch[$];   // parallel flag: word is a message header
    logic [15:0] pq[$];   // message being assembled
    bit          coll;
    int          rem_m, gap_m, mcnt, csz, nwd;
    bit          m_vld, m_rdy, m_to, m_ovf, m_seq;
    logic [15:0] m_dat;

    initial begin
        coll = 0; rem_m = 0; gap_m = 0; mcnt = 0;
        m_vld = 0; m_rdy = 0; m_to = 0; m_ovf = 0; m_seq = 0; m_dat = '0;
    end

    always @(posedge clk) begin
        if (!R_n) begin
            cq.delete(); ch.delete(); pq.delete();
            coll = 0; mcnt = 0; gap_m = 0; rem_m = 0;
            m_vld = 0; m_rdy = 0; m_to = 0; m_ovf = 0; m_seq = 0; m_dat = '0;
        end else begin
            csz   = cq.size();
            m_vld = 0;
            m_rdy = 0;
            if (rd_en && csz > 0) begin
                m_vld = 1;
                m_dat = cq.pop_front();
                if (ch.pop_front()) mcnt--;
            end
            if (ce) begin
                if (CW_DW) begin
                    pq.delete();
                    coll = 0;
                    if (!DAT_RX[10] && (DAT_RX[15:11] == RT || DAT_RX[15:11] == 5'd31)) begin
                        nwd = (DAT_RX[4:0] == 5'd0) ? 32 : int'(DAT_RX[4:0]);
                        if ((1 << AW) - csz >= nwd + 1) begin
                            pq.push_back(DAT_RX);
                            rem_m = nwd;
                            gap_m = 0;
                            coll  = 1;
                        end else begin
                            m_ovf = 1;
                        end
                    end
                end else if (coll) begin
                    pq.push_back(DAT_RX);
                    rem_m--;
                    gap_m = 0;
                    if (rem_m == 0) begin
                        foreach (pq[i]) begin
                            cq.push_back(pq[i]);
                            ch.push_back(i == 0);
                        end
                        pq.delete();
                        coll = 0;
                        mcnt++;
                        m_rdy = 1;
                    end
                end else begin
                    m_seq = 1;
                end
            end else if (ce_us && coll) begin
                gap_m++;
                if (gap_m == GAP) begin
                    pq.delete();
                    coll = 0;
                    m_to = 1;
                end
            end
        end
    end

    // Compare process: outputs are registered, sampled on the falling edge.
    always @(negedge clk) begin
        chk("rd_vld", rd_vld, m_vld);
        if (m_vld) chk("rd_dat", rd_dat, m_dat);
        chk("empty", empty, (cq.size() == 0));
        chk("msg_cnt", msg_cnt, mcnt);
        chk("msg_rdy", msg_rdy, m_rdy);
        chk("err_to", err_to, m_to);
        chk("err_ovf", err_ovf, m_ovf);
        chk("err_seq", err_seq, m_seq);
    end

    logic [15:0] rdq[$];
    always @(negedge clk) begin
        if (rd_vld) rdq.push_back(rd_dat);
    end

    // ---------------- stimulus ----------------
    task automatic wr(input logic [15:0] w, input bit cw);
        ce = 1'b1; DAT_RX = w; CW_DW = cw;
        @(negedge clk);
        ce = 1'b0; CW_DW = 1'b0;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            ce_us = 1'b1;
            @(negedge clk);
            ce_us = 1'b0;
        end
    endtask

    task automatic rd(input int k);
        rd_en = 1'b1;
        repeat (k) @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        R_n = 1'b0; ce = 1'b0; DAT_RX = '0; CW_DW = 1'b0; ce_us = 1'b0; rd_en = 1'b0;
        idle(2);
        #1;
        chk("rst_empty", empty, 1);
        chk("rst_msg_cnt", msg_cnt, 0);
        chk("rst_rd_vld", rd_vld, 0);
        chk("rst_rd_dat", rd_dat, 0);
        R_n = 1'b1;
        idle(1);

        // Basic 2-word message
        wr(16'h0842, 1); wr(16'hAAAA, 0); wr(16'h5555, 0);
        #1;
        chk("basic_msg_rdy", msg_rdy, 1);
        chk("basic_msg_cnt", msg_cnt, 1);
        rdq.delete();
        rd(3); idle(1); #1;
        chk("basic_nrd", rdq.size(), 3);
        if (rdq.size() == 3) begin
            chk("basic_w0", rdq[0], 16'h0842);
            chk("basic_w1", rdq[1], 16'hAAAA);
            chk("basic_w2", rdq[2], 16'h5555);
        end
        chk("basic_empty", empty, 1);
        chk("basic_cnt0", msg_cnt, 0);

        // Gap timeout, then a good message
        wr(16'h0843, 1); wr(16'h0001, 0); wr(16'h0002, 0);
        tick(25); #1;
        chk("to_flag", err_to, 1);
        chk("to_empty", empty, 1);
        rdq.delete();
        wr(16'h0821, 1); wr(16'hBEEF, 0);
        rd(2); idle(1); #1;
        chk("to_nrd", rdq.size(), 2);
        if (rdq.size() == 2) begin
            chk("to_w0", rdq[0], 16'h0821);
            chk("to_w1", rdq[1], 16'hBEEF);
        end

        // Address filter and broadcast
        wr(16'h1041, 1); idle(1); #1;
        chk("filt_empty", empty, 1);
        wr(16'hF841, 1); wr(16'h1234, 0); #1;
        chk("bcast_cnt", msg_cnt, 1);
        rd(2); idle(1);

        // Full-size message then overflow rejection
        wr(16'h0840, 1);
        for (int i = 0; i < 32; i++) wr(16'h1000 + 16'(i), 0);
        #1;
        chk("big_cnt", msg_cnt, 1);
        wr(16'h0840, 1); #1;
        chk("ovf_flag", err_ovf, 1);
        chk("ovf_cnt", msg_cnt, 1);
        rdq.delete();
        rd(34); idle(1); #1;
        chk("big_nrd", rdq.size(), 33);
        if (rdq.size() == 33) begin
            chk("big_w0", rdq[0], 16'h0840);
            chk("big_w1", rdq[1], 16'h1000);
            chk("big_w32", rdq[32], 16'h101F);
        end
        chk("big_cnt0", msg_cnt, 0);

        // Abort by a new CW mid-message
        wr(16'h0843, 1); wr(16'h1111, 0); wr(16'h0841, 1); wr(16'h2222, 0); #1;
        chk("abort_cnt", msg_cnt, 1);
        rdq.delete();
        rd(3); idle(1); #1;
        chk("abort_nrd", rdq.size(), 2);
        if (rdq.size() == 2) begin
            chk("abort_w0", rdq[0], 16'h0841);
            chk("abort_w1", rdq[1], 16'h2222);
        end

        // Orphan DW
        wr(16'h3333, 0); #1;
        chk("seq_flag", err_seq, 1);
        chk("seq_empty", empty, 1);

        // Reset in the middle of a message
        wr(16'h0843, 1); wr(16'h4444, 0);
        R_n = 1'b0;
        idle(1); #1;
        chk("mrst_to", err_to, 0);
        chk("mrst_ovf", err_ovf, 0);
        chk("mrst_seq", err_seq, 0);
        chk("mrst_empty", empty, 1);
        chk("mrst_cnt", msg_cnt, 0);
        chk("mrst_vld", rd_vld, 0);
        chk("mrst_dat", rd_dat, 0);
        R_n = 1'b1;
        idle(1);
        rdq.delete();
        wr(16'h0821, 1); wr(16'h0005, 0);
        rd(2); idle(1); #1;
        chk("post_nrd", rdq.size(), 2);
        if (rdq.size() == 2) begin
            chk("post_w0", rdq[0], 16'h0821);
            chk("post_w1", rdq[1], 16'h0005);
        end

        idle(2); #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
